ctrl_issue: RTL and testbench
=============================

CTRL_ISSUE -- requirements
Module: ctrl_issue

Interface
REQ-001 Parameter LENW, default 16: width of the word-count request and the address counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 xrst  input  1  reset; asynchronous, active-low.
REQ-004 req  input  1  one-cycle request pulse to start a burst; sampled only in IDLE.
REQ-005 len  input  LENW  number of valid words in the burst; sampled together with req.
REQ-006 pause  input  1  when high, holds the burst: no valid word issued and the counter is frozen.
REQ-007 abort  input  1  synchronous request to end the current burst early.
REQ-008 out_ctrl  ctrl_bus.out  3  start/valid/stop transmitter end; the same bus that is consumed by the downstream delay stages.
REQ-009 addr  output  LENW  index of the word currently marked valid.
REQ-010 busy  output  1  high from the accept cycle through the stop cycle.
REQ-011 done  output  1  one-cycle pulse in the cycle after stop.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 FSM states: IDLE, START, ACTIVE, STOP.
REQ-014 IDLE: req=1 latches len into the length register, moves to START, and sets busy=1 in the next cycle.
REQ-015 START: start=1, valid=0, addr=0 for exactly one cycle; next state is ACTIVE if len>0, else STOP.
REQ-016 ACTIVE, pause=0: valid=1, addr=k for the k-th word (0..len-1); addr increments by 1 per issued word.
REQ-017 ACTIVE, pause=1: valid=0, addr held, no word counted; pause SHALL have no effect in the IDLE, START and STOP states.
REQ-018 After word len-1 is issued, the next cycle SHALL enter STOP.
REQ-019 STOP: stop=1, valid=0 for one cycle, then IDLE; done=1 in the first IDLE cycle; busy=0 in that same cycle.
REQ-020 start, valid and stop SHALL be mutually exclusive in every cycle.
REQ-021 Latency: req at cycle t gives start at t+1 and the first valid at t+2 when there is no pause; stop follows at t+2+len+P, where P is the number of paused cycles.
REQ-022 req while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 abort in START or ACTIVE: the next cycle SHALL be STOP (stop=1); no further valid words are issued; abort outranks pause. abort in IDLE or STOP SHALL be ignored.
REQ-024 len=0: START is followed directly by STOP, with no valid cycles.
REQ-025 len=2^LENW-1: addr SHALL reach 2^LENW-2 without wrapping; the counter and comparison SHALL be LENW bits wide and unsigned.
REQ-026 done SHALL coincide with IDLE, so a req in the done cycle is accepted.

Reset
REQ-027 xrst low: the FSM SHALL go to IDLE immediately, asynchronously, including mid-burst.
REQ-028 xrst low: start=valid=stop=0, addr=0, busy=0, done=0 immediately.
REQ-029 Reset mid-burst: no stop pulse is emitted; the first cycle after release is in IDLE and accepts req.

Verification
REQ-030 req, len=4 at t0, no pause -> start at t1; valid at t2..t5 with addr 0,1,2,3; stop at t6; done at t7; busy at t1..t6.
REQ-031 len=4, pause high at t3..t4 -> valid at t2, t5, t6, t7 with addr 0,1,2,3; addr held at 1 during t3..t4; stop at t8.
REQ-032 len=0 -> start at t1, stop at t2, done at t3, valid never asserted.
REQ-033 len=8, abort pulse at t4 -> valid at t2..t4 (addr 0..2); stop at t5; done at t6; second req at t3 ignored.
REQ-034 len=6, xrst low at t4 -> all outputs 0 asynchronously, no stop pulse; req after release -> start one cycle later.
REQ-035 Back-to-back: req in the done cycle with len=1 -> start next cycle, one valid with addr=0, then stop.

Source files
------------

// File: rtl/ctrl_issue_if.sv
// Start/valid/stop control bus shared between the burst issuer and the
// downstream delay stages.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport out (output start, output valid, output stop);
  modport in  (input start, input valid, input stop);
endinterface

// File: rtl/ctrl_issue.sv
// Burst issuer: on a request, emits start, len valid words with a running
// address, then stop. Supports pause, early abort and async active-low reset.
module ctrl_issue #(
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            req,
  input  logic [LENW-1:0] len,
  input  logic            pause,
  input  logic            abort,
  ctrl_bus.out            out_ctrl,
  output logic [LENW-1:0] addr,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, START, ACTIVE, STOP} state_t;

  state_t          state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] addr_d;
  logic            start_q, start_d;
  logic            valid_q, valid_d;
  logic            stop_q, stop_d;
  logic            busy_d, done_d;
  logic            last_word;

  assign out_ctrl.start = start_q;
  assign out_ctrl.valid = valid_q;
  assign out_ctrl.stop  = stop_q;

  // The word on the bus this cycle is the final one of the burst.
  assign last_word = valid_q && (addr == len_q - LENW'(1));

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr    <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      stop_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr    <= addr_d;
      start_q <= start_d;
      valid_q <= valid_d;
      stop_q  <= stop_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Every output is decided one cycle ahead so the bus comes straight off flops.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr;
    start_d = 1'b0;
    valid_d = 1'b0;
    stop_d  = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = START;
          len_d   = len;
          addr_d  = '0;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (abort || (len_q == '0)) begin
          state_d = STOP;
          stop_d  = 1'b1;
        end else begin
          state_d = ACTIVE;
          addr_d  = '0;
          valid_d = !pause;
        end
      end

      ACTIVE: begin
        if (abort || last_word) begin
          state_d = STOP;
          stop_d  = 1'b1;
        end else begin
          if (valid_q) begin
            addr_d = addr + LENW'(1);
          end
          valid_d = !pause;
        end
      end

      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_issue.sv
// Scoreboard bench for ctrl_issue: each driven cycle queues the outputs expected
// in the following cycle; a monitor pops and compares just after every edge.
module tb_ctrl_issue;
  localparam int LENW = 4;

  typedef struct packed {
    logic            start;
    logic            valid;
    logic            stop;
    logic            busy;
    logic            done;
    logic            chk_addr;
    logic [LENW-1:0] addr;
  } exp_t;

  logic            clk = 1'b0;
  logic            xrst;
  logic            req;
  logic [LENW-1:0] len;
  logic            pause;
  logic            abort;
  logic [LENW-1:0] addr;
  logic            busy;
  logic            done;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  int    n_checks;
  int    n_fail;

  ctrl_bus bus ();

  ctrl_issue #(.LENW(LENW)) dut (
    .clk      (clk),
    .xrst     (xrst),
    .req      (req),
    .len      (len),
    .pause    (pause),
    .abort    (abort),
    .out_ctrl (bus),
    .addr     (addr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input bit s, input bit v, input bit p, input bit b,
                              input bit d, input bit ca, input int a);
    exp_t e;
    e.start    = s;
    e.valid    = v;
    e.stop     = p;
    e.busy     = b;
    e.done     = d;
    e.chk_addr = ca;
    e.addr     = LENW'(a);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input string name, input bit r, input int l,
                               input bit p, input bit a, input exp_t e);
    req   = r;
    len   = LENW'(l);
    pause = p;
    abort = a;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " start"}, int'(bus.start), 0);
    checkOutput({tag, " valid"}, int'(bus.valid), 0);
    checkOutput({tag, " stop"},  int'(bus.stop),  0);
    checkOutput({tag, " addr"},  int'(addr),      0);
    checkOutput({tag, " busy"},  int'(busy),      0);
    checkOutput({tag, " done"},  int'(done),      0);
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput("ctrl_exclusive",
                int'((int'(bus.start) + int'(bus.valid) + int'(bus.stop)) > 1), 0);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checkOutput({mon_n, " start"}, int'(bus.start), int'(mon_e.start));
      checkOutput({mon_n, " valid"}, int'(bus.valid), int'(mon_e.valid));
      checkOutput({mon_n, " stop"},  int'(bus.stop),  int'(mon_e.stop));
      checkOutput({mon_n, " busy"},  int'(busy),      int'(mon_e.busy));
      checkOutput({mon_n, " done"},  int'(done),      int'(mon_e.done));
      if (mon_e.chk_addr) begin
        checkOutput({mon_n, " addr"}, int'(addr), int'(mon_e.addr));
      end
    end
  end

  initial begin
    exp_t idle_e, start_e, stop_e, done_e, held1_e;
    idle_e  = mk(0, 0, 0, 0, 0, 0, 0);
    start_e = mk(1, 0, 0, 1, 0, 1, 0);
    stop_e  = mk(0, 0, 1, 1, 0, 0, 0);
    done_e  = mk(0, 0, 0, 0, 1, 0, 0);
    held1_e = mk(0, 0, 0, 1, 0, 1, 1);

    n_checks = 0;
    n_fail   = 0;
    xrst  = 1'b0;
    req   = 1'b0;
    len   = '0;
    pause = 1'b0;
    abort = 1'b0;

    #1;
    checkReset("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    xrst = 1'b1;
    @(posedge clk);
    #2;

    // Plain burst of four words.
    applyStimulus("basic", 1, 4, 0, 0, start_e);
    for (int k = 0; k < 4; k++) applyStimulus("basic", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, k));
    applyStimulus("basic", 0, 0, 0, 0, stop_e);
    applyStimulus("basic", 0, 0, 0, 0, done_e);
    applyStimulus("basic", 0, 0, 0, 0, idle_e);

    // Two paused cycles after the first word; address holds at 1.
    applyStimulus("pause", 1, 4, 0, 0, start_e);
    applyStimulus("pause", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 0));
    applyStimulus("pause", 0, 0, 1, 0, held1_e);
    applyStimulus("pause", 0, 0, 1, 0, held1_e);
    for (int k = 1; k < 4; k++) applyStimulus("pause", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, k));
    applyStimulus("pause", 0, 0, 0, 0, stop_e);
    applyStimulus("pause", 0, 0, 0, 0, done_e);
    applyStimulus("pause", 0, 0, 0, 0, idle_e);

    // Zero-length burst.
    applyStimulus("len0", 1, 0, 0, 0, start_e);
    applyStimulus("len0", 0, 0, 0, 0, stop_e);
    applyStimulus("len0", 0, 0, 0, 0, done_e);
    applyStimulus("len0", 0, 0, 0, 0, idle_e);

    // Abort (with pause also high) cuts the burst; a req while busy is dropped.
    applyStimulus("abort", 1, 8, 0, 0, start_e);
    applyStimulus("abort", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 0));
    applyStimulus("abort", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 1));
    applyStimulus("abort", 1, 2, 0, 0, mk(0, 1, 0, 1, 0, 1, 2));
    applyStimulus("abort", 0, 0, 1, 1, stop_e);
    applyStimulus("abort", 0, 0, 0, 0, done_e);
    applyStimulus("abort", 0, 0, 0, 0, idle_e);
    applyStimulus("abort_idle", 0, 0, 0, 1, idle_e);
    applyStimulus("abort_idle", 0, 0, 0, 0, idle_e);

    // Maximum length: address climbs to 2^LENW-2 without wrapping.
    applyStimulus("maxlen", 1, (1 << LENW) - 1, 0, 0, start_e);
    for (int k = 0; k < (1 << LENW) - 1; k++)
      applyStimulus("maxlen", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, k));
    applyStimulus("maxlen", 0, 0, 0, 0, stop_e);
    applyStimulus("maxlen", 0, 0, 0, 0, done_e);
    applyStimulus("maxlen", 0, 0, 0, 0, idle_e);

    // Reset mid-burst clears everything at once and emits no stop.
    applyStimulus("midreset", 1, 6, 0, 0, start_e);
    for (int k = 0; k < 3; k++) applyStimulus("midreset", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, k));
    xrst = 1'b0;
    #1;
    checkReset("async_reset");
    @(posedge clk);
    #2;
    checkReset("held_reset");
    @(negedge clk);
    xrst = 1'b1;
    applyStimulus("post_reset", 0, 0, 0, 0, idle_e);

    // Fresh burst, then a new req in the done cycle is accepted.
    applyStimulus("b2b", 1, 2, 0, 0, start_e);
    applyStimulus("b2b", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 0));
    applyStimulus("b2b", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 1));
    applyStimulus("b2b", 0, 0, 0, 0, stop_e);
    applyStimulus("b2b", 0, 0, 0, 0, done_e);
    applyStimulus("b2b_req_in_done", 1, 1, 0, 0, start_e);
    applyStimulus("b2b", 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 0));
    applyStimulus("b2b", 0, 0, 0, 0, stop_e);
    applyStimulus("b2b", 0, 0, 0, 0, done_e);
    applyStimulus("b2b", 0, 0, 0, 0, idle_e);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
